// File: rtl/alu_seq.sv
// Instruction sequencer for the 8-bit ALU: 4x8 register file, 3-state issue/exec/writeback FSM.
// Optional ALU_SEQ_FWD_EN: accept in WB with forwarding of the writeback result.
module alu_seq #(
  parameter int         NREG    = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [1:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        done,
  output logic [1:0]  done_rd
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nx;
  logic [7:0] regs [NREG];
  logic [1:0] rd_q;
  logic       s_q;
  logic       accept;
  logic [7:0] opa, opb;

  logic [2:0] f_op, f_sh;
  logic [1:0] f_rd, f_ra, f_rb;
  logic       f_s;
  logic       unused_rsvd;

  assign f_op        = in_instr[15:13];
  assign f_rd        = in_instr[12:11];
  assign f_ra        = in_instr[10:9];
  assign f_rb        = in_instr[8:7];
  assign f_sh        = in_instr[6:4];
  assign f_s         = in_instr[3];
  assign unused_rsvd = ^in_instr[2:0];

  assign accept  = in_valid & in_ready;
  assign rd_data = regs[rd_addr];
  assign done_rd = rd_q;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = EXEC;
      end
      EXEC: state_nx = WB;
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
`ifdef ALU_SEQ_FWD_EN
        in_ready = 1'b1;
        if (in_valid) state_nx = EXEC;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef ALU_SEQ_FWD_EN
  // Bypass the pending writeback; a same-cycle external write to rd wins.
  logic [7:0] fwd_val;
  assign fwd_val = (wr_en && wr_addr == rd_q) ? wr_data : alu_out;

  always_comb begin
    opa = regs[f_ra];
    opb = regs[f_rb];
    if (state == WB && f_ra == rd_q) opa = fwd_val;
    if (state == WB && f_rb == rd_q) opb = fwd_val;
  end
`else
  assign opa = regs[f_ra];
  assign opb = regs[f_rb];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 3'd0;
      alu_shamt <= 3'd0;
      rd_q      <= 2'd0;
      s_q       <= 1'b0;
    end else if (accept) begin
      alu_a     <= opa;
      alu_b     <= opb;
      alu_op    <= f_op;
      alu_shamt <= f_sh;
      rd_q      <= f_rd;
      s_q       <= f_s;
    end
  end

  // External write is issued last so it overrides a colliding writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
    end else begin
      if (state == WB) regs[rd_q] <= alu_out;
      if (wr_en)       regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flags <= 4'h0;
    else if (state == WB && s_q) flags <= alu_flags;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a registered 8-bit ALU model.
// Opcodes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 LSL 6 LSR 7 ASR; flags {Z,N,C,V}.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [7:0]  wr_data = 8'h0;
  logic [1:0]  rd_addr = 2'd0;
  logic [7:0]  rd_data;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op, alu_shamt;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        done;
  logic [1:0]  done_rd;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, LSL = 3'd5;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .flags(flags), .done(done), .done_rd(done_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic [2:0] sh);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    w = 9'h0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        r = a - b; c = (a >= b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: r = 8'($signed(a) >>> sh);
    endcase
    return {r, (r == 8'h0), r[7], c, v};
  endfunction

  always_ff @(posedge clk) begin
    {alu_out, alu_flags} <= alu_f(alu_a, alu_b, alu_op, alu_shamt);
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb,
                                     input logic [2:0] sh, input logic s);
    return {op, rd, ra, rb, sh, s, 3'b000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic rreg(input logic [1:0] a, output logic [7:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick;
      n++;
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: in_ready=%b required 1 within 10 cycles", in_ready);
    end
  endtask

  task automatic issue(input logic [15:0] ins);
    wait_ready;
    in_instr = ins;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    n_run++;
    if (in_ready !== 1'b1 || done !== 1'b0 || done_rd !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: ready=%b done=%b done_rd=%0d required 1 0 0",
               in_ready, done, done_rd);
    end
    n_run++;
    if (flags !== 4'h0 || alu_a !== 8'h0 || alu_b !== 8'h0 ||
        alu_op !== 3'd0 || alu_shamt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_regs: flags=%h a=%h b=%h op=%0d sh=%0d required all 0",
               flags, alu_a, alu_b, alu_op, alu_shamt);
    end
    for (int i = 0; i < 4; i++) begin
      rreg(2'(i), v);
      n_run++;
      if (v !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_rf%0d: got %h required 00", i, v);
      end
    end
  endtask

  task automatic test_add;
    logic [7:0] v;
    wreg(2'd0, 8'h05);
    wreg(2'd1, 8'h03);
    issue(mk(ADD, 2'd2, 2'd0, 2'd1, 3'd0, 1'b1));
    n_run++;
    if (in_ready !== 1'b0 || done !== 1'b0 || alu_a !== 8'h05 || alu_b !== 8'h03) begin
      n_fail++;
      $display("FAIL add_exec: ready=%b done=%b a=%h b=%h required 0 0 05 03",
               in_ready, done, alu_a, alu_b);
    end
    tick;
    n_run++;
    if (done !== 1'b1 || done_rd !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wb: done=%b done_rd=%0d ready=%b required 1 2 0",
               done, done_rd, in_ready);
    end
    tick;
    rreg(2'd2, v);
    n_run++;
    if (v !== 8'h08 || flags !== 4'b0000 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_result: r2=%h flags=%b done=%b ready=%b required 08 0000 0 1",
               v, flags, done, in_ready);
    end
  endtask

  task automatic test_sub_flags;
    logic [7:0] v;
    issue(mk(SUB, 2'd3, 2'd0, 2'd0, 3'd0, 1'b1));
    tick; tick;
    rreg(2'd3, v);
    n_run++;
    if (v !== 8'h00 || flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL sub_zero: r3=%h flags=%b required 00 1010", v, flags);
    end
    issue(mk(SUB, 2'd3, 2'd0, 2'd1, 3'd0, 1'b0));
    tick; tick;
    rreg(2'd3, v);
    n_run++;
    if (v !== 8'h02 || flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL sub_noflag: r3=%h flags=%b required 02 1010", v, flags);
    end
  endtask

  task automatic test_lsl;
    logic [7:0] v;
    wreg(2'd0, 8'h11);
    issue(mk(LSL, 2'd0, 2'd0, 2'd2, 3'd3, 1'b0) | 16'h0007);
    n_run++;
    if (in_ready !== 1'b0 || alu_op !== LSL || alu_shamt !== 3'd3) begin
      n_fail++;
      $display("FAIL lsl_issue: ready=%b op=%0d sh=%0d required 0 5 3",
               in_ready, alu_op, alu_shamt);
    end
    tick;
    n_run++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lsl_ready_wb: ready=%b required 0", in_ready);
    end
    tick;
    rreg(2'd0, v);
    n_run++;
    if (v !== 8'h88 || in_ready !== 1'b1 || flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL lsl_result: r0=%h ready=%b flags=%b required 88 1 1010",
               v, in_ready, flags);
    end
  endtask

  task automatic test_wr_collision;
    logic [7:0] v;
    wreg(2'd0, 8'h05);
    wreg(2'd1, 8'h03);
    issue(mk(ADD, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0));
    tick;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hAA;
    tick;
    wr_en = 1'b0;
    rreg(2'd2, v);
    n_run++;
    if (v !== 8'hAA) begin
      n_fail++;
      $display("FAIL wr_same_addr: r2=%h required AA", v);
    end
    issue(mk(ADD, 2'd3, 2'd0, 2'd1, 3'd0, 1'b0));
    tick;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
    tick;
    wr_en = 1'b0;
    rreg(2'd3, v);
    n_run++;
    if (v !== 8'h08) begin
      n_fail++;
      $display("FAIL wr_diff_wb: r3=%h required 08", v);
    end
    rreg(2'd1, v);
    n_run++;
    if (v !== 8'h77) begin
      n_fail++;
      $display("FAIL wr_diff_ext: r1=%h required 77", v);
    end
  endtask

  task automatic test_operand_snapshot;
    logic [7:0] v;
    wreg(2'd0, 8'h10);
    wreg(2'd1, 8'h01);
    wait_ready;
    in_instr = mk(ADD, 2'd3, 2'd0, 2'd1, 3'd0, 1'b0);
    in_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hF0;
    tick;
    in_valid = 1'b0;
    wr_addr = 2'd1; wr_data = 8'h0F;
    tick;
    wr_en = 1'b0;
    n_run++;
    if (alu_a !== 8'h10 || alu_b !== 8'h01) begin
      n_fail++;
      $display("FAIL snap_ops: a=%h b=%h required 10 01", alu_a, alu_b);
    end
    tick;
    rreg(2'd3, v);
    n_run++;
    if (v !== 8'h11) begin
      n_fail++;
      $display("FAIL snap_result: r3=%h required 11", v);
    end
    rreg(2'd0, v);
    n_run++;
    if (v !== 8'hF0) begin
      n_fail++;
      $display("FAIL snap_extwr: r0=%h required F0", v);
    end
  endtask

  task automatic test_reset_mid_exec;
    logic [7:0] v;
    logic       seen;
    issue(mk(ADD, 2'd2, 2'd0, 2'd1, 3'd0, 1'b1));
    rst_n = 1'b0;
    #1;
    n_run++;
    if (in_ready !== 1'b1 || done !== 1'b0 || alu_a !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_async: ready=%b done=%b a=%h required 1 0 00",
               in_ready, done, alu_a);
    end
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done) seen = 1'b1;
    end
    n_run++;
    if (seen !== 1'b0 || flags !== 4'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_abandon: done_seen=%b flags=%b ready=%b required 0 0000 1",
               seen, flags, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      rreg(2'(i), v);
      n_run++;
      if (v !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_rf%0d: got %h required 00", i, v);
      end
    end
  endtask

`ifdef ALU_SEQ_FWD_EN
  task automatic test_back_to_back;
    logic [7:0] v;
    wreg(2'd0, 8'h01);
    wreg(2'd1, 8'h02);
    issue(mk(ADD, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0));
    tick;
    in_instr = mk(ADD, 2'd3, 2'd2, 2'd2, 3'd0, 1'b0);
    in_valid = 1'b1;
    #1;
    n_run++;
    if (done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_wb_ready: done=%b ready=%b required 1 1", done, in_ready);
    end
    tick;
    in_valid = 1'b0;
    n_run++;
    if (done !== 1'b0 || alu_a !== 8'h03 || alu_b !== 8'h03) begin
      n_fail++;
      $display("FAIL fwd_ops: done=%b a=%h b=%h required 0 03 03", done, alu_a, alu_b);
    end
    tick;
    n_run++;
    if (done !== 1'b1 || done_rd !== 2'd3) begin
      n_fail++;
      $display("FAIL fwd_done2: done=%b done_rd=%0d required 1 3", done, done_rd);
    end
    tick;
    rreg(2'd3, v);
    n_run++;
    if (v !== 8'h06) begin
      n_fail++;
      $display("FAIL fwd_result: r3=%h required 06", v);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub_flags;
    test_lsl;
    test_wr_collision;
    test_operand_snapshot;
    test_reset_mid_exec;
`ifdef ALU_SEQ_FWD_EN
    test_back_to_back;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
